sqrt_job_scheduler: RTL and testbench
=====================================

# sqrt_job_scheduler

Controller that shares the single iterative square-root finder between several requesters. It arbitrates requests round-robin and sequences the finder's start/done handshake, with a watchdog on each job. It returns each result to its originating requester and drives the value shown on the seven-segment display path through the binary-to-BCD converter. It sits between the requester sources and the square-root datapath, replacing direct wiring of the start and data inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand width; result width is DW/2
- TIMEOUT, 32, max cycles in WAIT before a job is aborted (≥ 2)
- clk  in  1  system clock
- clr_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester job request
- req_data  in  NREQ*DW  operands, requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept pulse
- sq_start  out  1  start pulse to square-root finder
- sq_a  out  DW  operand to finder, held stable from ISSUE through WAIT
- sq_done  in  1  finder result-valid pulse
- sq_sqrt  in  DW/2  finder result
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  $clog2(NREQ)  requester index of resp
- resp_sqrt  out  DW/2  result (all ones on error)
- resp_err  out  1  job timed out
- busy  out  1  high in any state other than IDLE
- disp_val  out  DW  value for BCD/display path

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from (last_grant+1) mod NREQ.
  - Assert req_ready[grant] this cycle; the transfer completes on req_valid & req_ready.
  - Latch the operand into sq_a and the grant index into the id register.
  - Set disp_val to the operand and go to ISSUE.
- ISSUE: sq_start=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Increment the watchdog each cycle.
  - On sq_done: latch sq_sqrt, resp_err=0, go to RESP.
  - When the counter reaches TIMEOUT-1 without sq_done: resp_sqrt=all ones, resp_err=1, go to RESP.
  - sq_done in the same cycle as the timeout takes priority, so the job is not an error.
- RESP:
  - resp_valid=1 for one cycle with resp_id, resp_sqrt and resp_err.
  - disp_val={zeros, resp_sqrt}.
  - Update last_grant and return to IDLE.
- resp_id, resp_sqrt and resp_err hold their values until the next RESP.
- sq_done outside WAIT is ignored.
- Requesters drop req_valid only after req_ready; deasserting it earlier is legal and simply removes the request.
- At most one job is in flight; no queueing.

## Timing
- Reset values: state=IDLE; req_ready=0; sq_start=0; sq_a=0; resp_valid=0; resp_id=0; resp_sqrt=0; resp_err=0; busy=0; disp_val=0; last_grant=NREQ-1, so requester 0 wins first.
- Job cycle sequence:
  - Accept at cycle t.
  - sq_start at t+1.
  - sq_done sampled at t+1+k, with k≥1.
  - resp_valid at t+2+k.
  - The next accept is possible at t+3+k.
- Timeout response: resp_valid at t+2+TIMEOUT.
- All outputs are registered; req_ready is combinational from state, req_valid and last_grant.
- Reset mid-job: outputs return to reset values immediately and no response is issued for the aborted job. The finder is re-started on the next job.

## Structure
- Package sqrt_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the default TIMEOUT;
  - the ERR_RESULT constant (all ones).
- Sub-module rr_arbiter(NREQ): inputs req and last_grant; outputs a one-hot grant and its encoded index. It is purely combinational and reusable by other shared display/datapath resources.
- Top contains the FSM, watchdog counter and output registers.

## Test plan
- After reset, requester 2 posts 8'd144 with a model returning 12 after 5 cycles. Expect:
  - req_ready=4'b0100;
  - sq_start one cycle later with sq_a=144;
  - disp_val=144 during WAIT;
  - resp_valid with id=2, sqrt=12, err=0;
  - disp_val=12.
- All four requesters valid continuously, operands 0, 1, 49, 255. Expect grants 0,1,2,3,0 and results 0, 1, 7, 15 with matching ids.
- Finder model never asserts sq_done. Expect resp at accept+2+TIMEOUT with sqrt=4'hF and err=1, then the next request is accepted normally.
- sq_done asserted on exactly the timeout cycle. Expect err=0 and the finder's value returned.
- Assert clr_n low during WAIT. Expect all outputs back at reset values and no resp_valid. After release, requester 0 is granted first.
- Spurious sq_done in IDLE and req_valid dropped before any grant. Expect no resp_valid, no sq_start and busy stays 0.

Source files
------------

// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the square-root job scheduler.
// Imported by the scheduler top and anything that decodes its state.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int TIMEOUT_DEFAULT = 32;

    // Wide enough for any supported result width; users take the low bits.
    localparam logic [31:0] ERR_RESULT = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request searching
// upward from the slot after last_grant, wrapping at NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // The last slot visited (i == NREQ) is last_grant itself, so a sole
        // requester still wins back-to-back.
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_grant) + i) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sqrt_job_scheduler.sv
// Shares one iterative square-root finder between NREQ requesters, with a
// per-job watchdog and a display value that tracks operand then result.
//
// state | meaning
// IDLE  | waiting for a request; accept and latch operand on grant
// ISSUE | one-cycle start pulse to the finder, watchdog loaded
// WAIT  | waiting for sq_done or watchdog terminal count
// RESP  | one-cycle response pulse, round-robin pointer advanced
module sqrt_job_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int DW      = 8,
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int IW      = $clog2(NREQ),
    localparam int RW      = DW / 2
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            sq_start,
    output logic [DW-1:0]   sq_a,
    input  logic            sq_done,
    input  logic [RW-1:0]   sq_sqrt,
    output logic            resp_valid,
    output logic [IW-1:0]   resp_id,
    output logic [RW-1:0]   resp_sqrt,
    output logic            resp_err,
    output logic            busy,
    output logic [DW-1:0]   disp_val
);

    localparam int CW = $clog2(TIMEOUT);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] job_id_q, job_id_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic [DW-1:0] sq_a_q, sq_a_d;
    logic          sq_start_q, sq_start_d;
    logic          resp_valid_q, resp_valid_d;
    logic [IW-1:0] resp_id_q, resp_id_d;
    logic [RW-1:0] resp_sqrt_q, resp_sqrt_d;
    logic          resp_err_q, resp_err_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] disp_val_q, disp_val_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [DW-1:0]   grant_data;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign grant_data = req_data[int'(grant_idx)*DW +: DW];
    assign req_ready  = (state_q == IDLE) ? grant : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        job_id_d     = job_id_q;
        wdog_d       = wdog_q;
        sq_a_d       = sq_a_q;
        sq_start_d   = 1'b0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_sqrt_d  = resp_sqrt_q;
        resp_err_d   = resp_err_q;
        disp_val_d   = disp_val_q;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    job_id_d   = grant_idx;
                    sq_a_d     = grant_data;
                    disp_val_d = grant_data;
                    sq_start_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Down-counter: terminal count 0 lands on the TIMEOUT-th WAIT cycle.
                wdog_d  = CW'(TIMEOUT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (wdog_q != '0) begin
                    wdog_d = wdog_q - 1'b1;
                end
                if (sq_done) begin
                    resp_sqrt_d  = sq_sqrt;
                    resp_err_d   = 1'b0;
                    resp_id_d    = job_id_q;
                    resp_valid_d = 1'b1;
                    disp_val_d   = DW'(sq_sqrt);
                    state_d      = RESP;
                end else if (wdog_q == '0) begin
                    resp_sqrt_d  = ERR_RESULT[RW-1:0];
                    resp_err_d   = 1'b1;
                    resp_id_d    = job_id_q;
                    resp_valid_d = 1'b1;
                    disp_val_d   = DW'(ERR_RESULT[RW-1:0]);
                    state_d      = RESP;
                end
            end
            RESP: begin
                last_grant_d = job_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            job_id_q     <= '0;
            wdog_q       <= '0;
            sq_a_q       <= '0;
            sq_start_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sqrt_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            disp_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            job_id_q     <= job_id_d;
            wdog_q       <= wdog_d;
            sq_a_q       <= sq_a_d;
            sq_start_q   <= sq_start_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sqrt_q  <= resp_sqrt_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            disp_val_q   <= disp_val_d;
        end
    end

    assign sq_start   = sq_start_q;
    assign sq_a       = sq_a_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sqrt  = resp_sqrt_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign disp_val   = disp_val_q;

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// Directed bench for sqrt_job_scheduler: the finder is played by the stimulus
// sequence itself, with hand-computed results and cycle-exact response timing.
module tb_sqrt_job_scheduler;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 32;

    logic             clk;
    logic             clr_n;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             sq_start;
    logic [DW-1:0]    sq_a;
    logic             sq_done;
    logic [DW/2-1:0]  sq_sqrt;
    logic             resp_valid;
    logic [1:0]       resp_id;
    logic [DW/2-1:0]  resp_sqrt;
    logic             resp_err;
    logic             busy;
    logic [DW-1:0]    disp_val;

    int n_vec = 0;
    int n_err = 0;

    sqrt_job_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sq_start   (sq_start),
        .sq_a       (sq_a),
        .sq_done    (sq_done),
        .sq_sqrt    (sq_sqrt),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sqrt  (resp_sqrt),
        .resp_err   (resp_err),
        .busy       (busy),
        .disp_val   (disp_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"},  32'(req_ready),  32'h0);
        chk({tag, " sq_start"},   32'(sq_start),   32'h0);
        chk({tag, " sq_a"},       32'(sq_a),       32'h0);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, " resp_id"},    32'(resp_id),    32'h0);
        chk({tag, " resp_sqrt"},  32'(resp_sqrt),  32'h0);
        chk({tag, " resp_err"},   32'(resp_err),   32'h0);
        chk({tag, " busy"},       32'(busy),       32'h0);
        chk({tag, " disp_val"},   32'(disp_val),   32'h0);
    endtask

    // Entered in an IDLE cycle t with requests already driven. The finder
    // answers (if drive) in cycle s+k where s=t+1 is the sq_start cycle.
    task automatic run_job(input string tag, input int exp_id, input logic [7:0] exp_a,
                           input int k, input logic drive, input logic [3:0] val,
                           input logic [3:0] exp_sqrt, input logic exp_err);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << exp_id;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
        tick();
        chk({tag, " sq_start"}, 32'(sq_start), 32'h1);
        chk({tag, " sq_a"},     32'(sq_a),     32'(exp_a));
        chk({tag, " busy"},     32'(busy),     32'h1);
        tick();
        chk({tag, " start_once"}, 32'(sq_start), 32'h0);
        chk({tag, " disp_wait"},  32'(disp_val), 32'(exp_a));
        for (int i = 1; i < k; i++) tick();
        chk({tag, " early_resp"}, 32'(resp_valid), 32'h0);
        if (drive) begin
            sq_done = 1'b1;
            sq_sqrt = val;
        end
        tick();
        sq_done = 1'b0;
        sq_sqrt = '0;
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'h1);
        chk({tag, " resp_id"},    32'(resp_id),    32'(exp_id));
        chk({tag, " resp_sqrt"},  32'(resp_sqrt),  32'(exp_sqrt));
        chk({tag, " resp_err"},   32'(resp_err),   32'(exp_err));
        chk({tag, " disp_res"},   32'(disp_val),   32'(exp_sqrt));
        tick();
        chk({tag, " resp_pulse"}, 32'(resp_valid), 32'h0);
        chk({tag, " resp_hold"},  32'(resp_sqrt),  32'(exp_sqrt));
        chk({tag, " idle_busy"},  32'(busy),       32'h0);
    endtask

    initial begin
        clr_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        sq_done   = 1'b0;
        sq_sqrt   = '0;
        repeat (2) tick();
        chk_reset_vals("por");
        clr_n = 1'b1;
        tick();

        // Requester 2, operand 144, finder answers 12 after 5 cycles.
        req_data  = {8'd0, 8'd144, 8'd0, 8'd0};
        req_valid = 4'b0100;
        run_job("j144", 2, 8'd144, 5, 1'b1, 4'd12, 4'd12, 1'b0);
        req_valid = '0;
        tick();

        // Abort a job on requester 1 mid-WAIT; pointer stays at 2 without reset.
        req_data  = {8'd0, 8'd0, 8'd100, 8'd0};
        req_valid = 4'b0010;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (3) tick();
        clr_n = 1'b0;
        #1;
        chk_reset_vals("midjob");
        tick();
        chk("midjob no_resp", 32'(resp_valid), 32'h0);
        tick();
        chk("midjob no_resp2", 32'(resp_valid), 32'h0);
        clr_n = 1'b1;

        // Round robin after reset: requester 0 first, then 1,2,3,0.
        req_data  = {8'd255, 8'd49, 8'd1, 8'd0};
        req_valid = 4'b1111;
        run_job("rr0", 0, 8'd0,   1, 1'b1, 4'd0,  4'd0,  1'b0);
        run_job("rr1", 1, 8'd1,   2, 1'b1, 4'd1,  4'd1,  1'b0);
        run_job("rr2", 2, 8'd49,  3, 1'b1, 4'd7,  4'd7,  1'b0);
        run_job("rr3", 3, 8'd255, 4, 1'b1, 4'd15, 4'd15, 1'b0);
        run_job("rr4", 0, 8'd0,   1, 1'b1, 4'd0,  4'd0,  1'b0);
        req_valid = '0;
        tick();

        // Finder never answers: error response at accept+2+TIMEOUT.
        req_data  = {8'd0, 8'd0, 8'd100, 8'd0};
        req_valid = 4'b0010;
        run_job("tmo", 1, 8'd100, TIMEOUT, 1'b0, 4'd0, 4'hF, 1'b1);
        run_job("post_tmo", 1, 8'd100, 2, 1'b1, 4'd10, 4'd10, 1'b0);
        req_valid = '0;
        tick();

        // sq_done on the timeout cycle wins over the watchdog.
        req_data  = {8'd81, 8'd0, 8'd0, 8'd0};
        req_valid = 4'b1000;
        run_job("tmo_edge", 3, 8'd81, TIMEOUT, 1'b1, 4'd9, 4'd9, 1'b0);
        req_valid = '0;
        tick();

        // Spurious sq_done in IDLE and a request withdrawn within the cycle.
        sq_done   = 1'b1;
        sq_sqrt   = 4'd3;
        req_valid = 4'b0001;
        #2;
        req_valid = '0;
        tick();
        sq_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("spur resp_valid", 32'(resp_valid), 32'h0);
            chk("spur sq_start",   32'(sq_start),   32'h0);
            chk("spur busy",       32'(busy),       32'h0);
            tick();
        end
        chk("spur resp_sqrt", 32'(resp_sqrt), 32'h9);
        chk("spur disp_val",  32'(disp_val),  32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
